// File: rtl/traffic_phase_timer.sv
// Phase sequencer for one traffic-light approach: divides the system clock to a
// one-second tick, steps RED -> GREEN -> YELLOW -> RED and drives lamps and countdown.
module traffic_phase_timer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int RED_TIME      = 30,
  parameter int GREEN_TIME    = 25,
  parameter int YELLOW_TIME   = 5
) (
  input  logic       clock1KHz,
  input  logic       rst,
  input  logic       hold,
  input  logic       night,
  output logic       R,
  output logic [7:0] NUM,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic       sec_tick,
  output logic [1:0] phase
);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2, NIGHT = 2'd3} phase_t;

  phase_t          state, state_n;
  logic [7:0]      num_n;
  logic [PW-1:0]   presc, presc_n;
  logic            tick_n;
  logic            flash, flash_n;
  logic            at_end;

  assign at_end = (presc == PW'(TICKS_PER_SEC - 1));
  assign phase  = state;

  // Priority: rst (in the register) > night > hold > tick.
  always_comb begin
    state_n = state;
    num_n   = NUM;
    presc_n = presc;
    tick_n  = 1'b0;
    flash_n = flash;
    if (state == NIGHT) begin
      if (!night) begin
        state_n = RED;
        num_n   = 8'(RED_TIME);
        presc_n = '0;
        flash_n = 1'b0;
      end else begin
        presc_n = at_end ? '0 : presc + PW'(1);
        if (at_end) begin
          tick_n  = 1'b1;
          flash_n = ~flash;
        end
      end
    end else if (night) begin
      state_n = NIGHT;
      num_n   = 8'd0;
      presc_n = '0;
      flash_n = 1'b1;
    end else if (!hold) begin
      presc_n = at_end ? '0 : presc + PW'(1);
      if (at_end) begin
        tick_n = 1'b1;
        if (NUM > 8'd1) begin
          num_n = NUM - 8'd1;
        end else begin
          case (state)
            RED:     begin state_n = GREEN;  num_n = 8'(GREEN_TIME);  end
            GREEN:   begin state_n = YELLOW; num_n = 8'(YELLOW_TIME); end
            default: begin state_n = RED;    num_n = 8'(RED_TIME);    end
          endcase
        end
      end
    end
  end

  // Lamp and R registers are loaded from the next state so they change on the same edge.
  always_ff @(posedge clock1KHz) begin
    if (rst) begin
      state       <= RED;
      NUM         <= 8'(RED_TIME);
      presc       <= '0;
      sec_tick    <= 1'b0;
      flash       <= 1'b0;
      R           <= 1'b1;
      lamp_red    <= 1'b1;
      lamp_yellow <= 1'b0;
      lamp_green  <= 1'b0;
    end else begin
      state       <= state_n;
      NUM         <= num_n;
      presc       <= presc_n;
      sec_tick    <= tick_n;
      flash       <= flash_n;
      R           <= (state_n == RED);
      lamp_red    <= (state_n == RED);
      lamp_green  <= (state_n == GREEN);
      lamp_yellow <= (state_n == YELLOW) || ((state_n == NIGHT) && flash_n);
    end
  end
endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer with 4 ticks per second and 5/4/2 s phases.
module tb_traffic_phase_timer;
  logic       clk = 1'b0;
  logic       rst, hold, night;
  logic       r_out, lamp_red, lamp_yellow, lamp_green, sec_tick;
  logic [7:0] num;
  logic [1:0] phase;
  int checks = 0;
  int errors = 0;

  traffic_phase_timer #(
    .TICKS_PER_SEC(4), .RED_TIME(5), .GREEN_TIME(4), .YELLOW_TIME(2)
  ) dut (
    .clock1KHz(clk), .rst(rst), .hold(hold), .night(night),
    .R(r_out), .NUM(num), .lamp_red(lamp_red), .lamp_yellow(lamp_yellow),
    .lamp_green(lamp_green), .sec_tick(sec_tick), .phase(phase)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; hold = 1'b0; night = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({r_out, num, lamp_red, lamp_yellow, lamp_green, sec_tick, phase} !== {1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_state: got R=%b NUM=%0d lamps=%b%b%b tick=%b phase=%0d, exp R=1 NUM=5 lamps=100 tick=0 phase=0",
               r_out, num, lamp_red, lamp_yellow, lamp_green, sec_tick, phase);
    end
    step(3);
    checks++;
    if ({num, sec_tick} !== {8'd5, 1'b0}) begin
      errors++;
      $display("FAIL first_tick_early: got NUM=%0d tick=%b, exp NUM=5 tick=0", num, sec_tick);
    end
  endtask

  task automatic test_countdown();
    logic [7:0] exp_num [5];
    exp_num = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd4};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(3);
      checks++;
      if (sec_tick !== 1'b0) begin
        errors++;
        $display("FAIL countdown_no_tick[%0d]: got tick=%b, exp 0", k, sec_tick);
      end
      step(1);
      checks++;
      if ({num, sec_tick} !== {exp_num[k], 1'b1}) begin
        errors++;
        $display("FAIL countdown[%0d]: got NUM=%0d tick=%b, exp NUM=%0d tick=1", k, num, sec_tick, exp_num[k]);
      end
    end
    checks++;
    if ({r_out, lamp_red, lamp_yellow, lamp_green} !== 4'b0001) begin
      errors++;
      $display("FAIL to_green: got R=%b lamps=%b%b%b, exp R=0 lamps=001", r_out, lamp_red, lamp_yellow, lamp_green);
    end
  endtask

  task automatic test_full_cycle();
    logic [7:0] exp_num [11];
    logic       exp_r   [11];
    logic [2:0] exp_lmp [11];
    int ticks = 0;
    int yel_cycles = 0;
    exp_num = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd5};
    exp_r   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_lmp = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100};
    do_reset();
    for (int c = 1; c <= 44; c++) begin
      step(1);
      if (lamp_yellow) yel_cycles++;
      if (sec_tick) begin
        checks++;
        if (ticks >= 11 || {r_out, num, lamp_red, lamp_yellow, lamp_green} !== {exp_r[ticks % 11], exp_num[ticks % 11], exp_lmp[ticks % 11]}) begin
          errors++;
          $display("FAIL full_cycle_tick%0d@%0d: got R=%b NUM=%0d lamps=%b%b%b, exp R=%b NUM=%0d lamps=%b",
                   ticks, c, r_out, num, lamp_red, lamp_yellow, lamp_green,
                   exp_r[ticks % 11], exp_num[ticks % 11], exp_lmp[ticks % 11]);
        end
        ticks++;
      end
    end
    checks++;
    if (ticks != 11) begin
      errors++;
      $display("FAIL full_cycle_ticks: got %0d, exp 11", ticks);
    end
    checks++;
    if (yel_cycles != 8) begin
      errors++;
      $display("FAIL yellow_cycles: got %0d, exp 8", yel_cycles);
    end
  endtask

  task automatic test_hold();
    int seen = 0;
    do_reset();
    step(10);  // NUM=3, prescaler=2
    hold = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (sec_tick !== 1'b0 || num !== 8'd3) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL hold_freeze: got %0d bad cycles (NUM=%0d), exp 0", seen, num);
    end
    hold = 1'b0;
    step(1);
    checks++;
    if ({num, sec_tick} !== {8'd3, 1'b0}) begin
      errors++;
      $display("FAIL hold_resume1: got NUM=%0d tick=%b, exp NUM=3 tick=0", num, sec_tick);
    end
    step(1);
    checks++;
    if ({num, sec_tick} !== {8'd2, 1'b1}) begin
      errors++;
      $display("FAIL hold_resume2: got NUM=%0d tick=%b, exp NUM=2 tick=1", num, sec_tick);
    end
    step(7);  // NUM=1, prescaler=3: boundary due next edge
    hold = 1'b1;
    step(3);
    checks++;
    if ({r_out, num, sec_tick} !== {1'b1, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL hold_boundary: got R=%b NUM=%0d tick=%b, exp R=1 NUM=1 tick=0", r_out, num, sec_tick);
    end
    hold = 1'b0;
    step(1);
    checks++;
    if ({r_out, num, lamp_green, sec_tick} !== {1'b0, 8'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL hold_deferred: got R=%b NUM=%0d green=%b tick=%b, exp R=0 NUM=4 green=1 tick=1",
               r_out, num, lamp_green, sec_tick);
    end
  endtask

  task automatic test_night();
    do_reset();
    step(28);  // GREEN, NUM=2
    checks++;
    if ({r_out, num, lamp_green} !== {1'b0, 8'd2, 1'b1}) begin
      errors++;
      $display("FAIL night_pre: got R=%b NUM=%0d green=%b, exp R=0 NUM=2 green=1", r_out, num, lamp_green);
    end
    night = 1'b1;
    step(1);
    checks++;
    if ({r_out, num, lamp_red, lamp_yellow, lamp_green, phase} !== {1'b0, 8'd0, 3'b010, 2'd3}) begin
      errors++;
      $display("FAIL night_entry: got R=%b NUM=%0d lamps=%b%b%b phase=%0d, exp R=0 NUM=0 lamps=010 phase=3",
               r_out, num, lamp_red, lamp_yellow, lamp_green, phase);
    end
    hold = 1'b1;  // ignored in night
    step(3);
    checks++;
    if (lamp_yellow !== 1'b1) begin
      errors++;
      $display("FAIL night_flash_hold: got yellow=%b, exp 1", lamp_yellow);
    end
    step(1);
    checks++;
    if ({lamp_yellow, num} !== {1'b0, 8'd0}) begin
      errors++;
      $display("FAIL night_flash_off: got yellow=%b NUM=%0d, exp yellow=0 NUM=0", lamp_yellow, num);
    end
    step(4);
    checks++;
    if (lamp_yellow !== 1'b1) begin
      errors++;
      $display("FAIL night_flash_on: got yellow=%b, exp 1", lamp_yellow);
    end
    night = 1'b0; hold = 1'b0;
    step(1);
    checks++;
    if ({r_out, num, lamp_red, lamp_yellow, lamp_green, phase} !== {1'b1, 8'd5, 3'b100, 2'd0}) begin
      errors++;
      $display("FAIL night_exit: got R=%b NUM=%0d lamps=%b%b%b phase=%0d, exp R=1 NUM=5 lamps=100 phase=0",
               r_out, num, lamp_red, lamp_yellow, lamp_green, phase);
    end
    step(4);
    checks++;
    if ({num, sec_tick} !== {8'd4, 1'b1}) begin
      errors++;
      $display("FAIL night_exit_presc: got NUM=%0d tick=%b, exp NUM=4 tick=1", num, sec_tick);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    step(43);  // YELLOW, NUM=1, tick due next edge
    checks++;
    if ({num, lamp_yellow, phase} !== {8'd1, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL rstprio_pre: got NUM=%0d yellow=%b phase=%0d, exp NUM=1 yellow=1 phase=2", num, lamp_yellow, phase);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if ({r_out, num, lamp_red, lamp_yellow, lamp_green, sec_tick} !== {1'b1, 8'd5, 3'b100, 1'b0}) begin
      errors++;
      $display("FAIL rstprio: got R=%b NUM=%0d lamps=%b%b%b tick=%b, exp R=1 NUM=5 lamps=100 tick=0",
               r_out, num, lamp_red, lamp_yellow, lamp_green, sec_tick);
    end
    step(3);
    checks++;
    if ({num, sec_tick} !== {8'd5, 1'b0}) begin
      errors++;
      $display("FAIL rstprio_presc: got NUM=%0d tick=%b, exp NUM=5 tick=0", num, sec_tick);
    end
  endtask

  task automatic test_combo();
    do_reset();
    hold = 1'b1; night = 1'b1;
    step(1);
    checks++;
    if ({phase, num, lamp_yellow, r_out} !== {2'd3, 8'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL hold_night: got phase=%0d NUM=%0d yellow=%b R=%b, exp phase=3 NUM=0 yellow=1 R=0",
               phase, num, lamp_yellow, r_out);
    end
    hold = 1'b0; rst = 1'b1;
    step(1);
    checks++;
    if ({phase, num, r_out, lamp_red, lamp_yellow} !== {2'd0, 8'd5, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rst_night: got phase=%0d NUM=%0d R=%b red=%b yellow=%b, exp phase=0 NUM=5 R=1 red=1 yellow=0",
               phase, num, r_out, lamp_red, lamp_yellow);
    end
    rst = 1'b0; night = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; night = 1'b0;
    test_reset();
    test_countdown();
    test_full_cycle();
    test_hold();
    test_night();
    test_reset_priority();
    test_combo();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
